// File: rtl/qvga_frame_reader.sv
// ============================================================================
//  Module      : qvga_frame_reader
//  Description : Display-side reader for a 320x240 RGB565 frame buffer.
//                Generates 640x480@60 VGA timing on the 25 MHz pixel clock,
//                reads the buffer through its synchronous read port with a
//                2x upscale in both axes, and drives 4-bit-per-channel RGB.
//  Ports       : pclk        - pixel clock
//                reset       - synchronous reset, active-high
//                oe, rAddr   - frame buffer read enable / address
//                rData       - RGB565 read data, one pclk after oe/rAddr
//                h_sync      - VGA hsync, active-low
//                v_sync      - VGA vsync, active-low
//                de          - display enable (visible pixels)
//                red/green/blue - 4-bit colour channels
//                frame_done  - one-cycle pulse after the last visible pixel
//  Options     : QVGA_READER_GRAY_EN - convert pixels to grayscale
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qvga_frame_reader #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int SRC_WIDTH    = 320
) (
    input  logic        pclk,
    input  logic        reset,
    output logic        oe,
    output logic [16:0] rAddr,
    input  logic [15:0] rData,
    output logic        h_sync,
    output logic        v_sync,
    output logic        de,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_done
);

    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  HS_FIRST = 10'(H_SYNC_START);
    localparam logic [9:0]  HS_LAST  = 10'(H_SYNC_END);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_SYNC_START);
    localparam logic [9:0]  VS_LAST  = 10'(V_SYNC_END);
    localparam logic [16:0] STRIDE   = 17'(SRC_WIDTH);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode counters and issue the buffer read
    // ------------------------------------------------------------------
    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic [16:0] pix_addr;

    assign vis0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs0  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs0  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    // Halving both counters gives the 2x upscale: each source pixel covers
    // two columns and each source line is fetched on two display lines.
    assign pix_addr = 17'(v_cnt[9:1]) * STRIDE + 17'(h_cnt[9:1]);

    // Gated by reset so the read port sits idle while reset is held, even
    // though the counters then point at the first visible pixel.
    assign oe    = vis0 && !reset;
    assign rAddr = oe ? pix_addr : 17'd0;

    // ------------------------------------------------------------------
    // Stage 1: delay timing flags by one cycle to meet rData
    // ------------------------------------------------------------------
    logic vis1;
    logic hs1;
    logic vs1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            vis1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
        end else begin
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel conversion from the returned RGB565 word
    // ------------------------------------------------------------------
    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;

`ifdef QVGA_READER_GRAY_EN
    // Luma weights 77/150/29 (out of 256) applied after widening R5/B5 to
    // 8 bits (x8) and G6 to 8 bits (x4); the sum never exceeds 16 bits.
    logic [15:0] gray_sum;
    logic [3:0]  gray_nib;

    assign gray_sum = 16'(rData[15:11]) * 16'd616
                    + 16'(rData[10:5])  * 16'd600
                    + 16'(rData[4:0])   * 16'd232;
    assign gray_nib = 4'(gray_sum >> 12);
    assign pix_r    = gray_nib;
    assign pix_g    = gray_nib;
    assign pix_b    = gray_nib;
`else
    // Keep the top four bits of each RGB565 field.
    logic unused_rdata_bits;

    assign pix_r = rData[15:12];
    assign pix_g = rData[10:7];
    assign pix_b = rData[4:1];
    assign unused_rdata_bits = ^{rData[11], rData[6:5], rData[0]};
`endif

    // ------------------------------------------------------------------
    // Stage 2: registered pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            de         <= 1'b0;
            red        <= 4'd0;
            green      <= 4'd0;
            blue       <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            h_sync     <= hs1;
            v_sync     <= vs1;
            de         <= vis1;
            // Blanking forces black so stray read data never reaches the pins.
            if (vis1) begin
                red   <= pix_r;
                green <= pix_g;
                blue  <= pix_b;
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
            frame_done <= (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qvga_frame_reader.sv
`default_nettype none

module tb_qvga_frame_reader;

    // Reduced raster for the long-running checks
    localparam int S_HA = 40, S_HT = 50, S_HSS = 42, S_HSE = 45;
    localparam int S_VA = 30, S_VT = 35, S_VSS = 31, S_VSE = 32, S_SW = 20;
    // Full VGA raster
    localparam int F_HA = 640, F_HT = 800, F_HSS = 656, F_HSE = 751;
    localparam int F_VA = 480, F_VT = 525, F_VSS = 490, F_VSE = 491, F_SW = 320;

    logic pclk = 1'b0;
    always #20 pclk = ~pclk;

    logic [15:0] mem [0:76799];

    // ---------------- small-raster DUT ----------------
    logic        rst_s;
    logic        oe_s, hs_s, vs_s, de_s, fd_s;
    logic [16:0] addr_s;
    logic [15:0] rdata_s;
    logic [3:0]  r_s, g_s, b_s;

    qvga_frame_reader #(
        .H_ACTIVE(S_HA), .H_TOTAL(S_HT), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE),
        .V_ACTIVE(S_VA), .V_TOTAL(S_VT), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE),
        .SRC_WIDTH(S_SW)
    ) dut (
        .pclk(pclk), .reset(rst_s), .oe(oe_s), .rAddr(addr_s), .rData(rdata_s),
        .h_sync(hs_s), .v_sync(vs_s), .de(de_s), .red(r_s), .green(g_s),
        .blue(b_s), .frame_done(fd_s)
    );

    // ---------------- full-raster DUT ----------------
    logic        rst_f;
    logic        oe_f, hs_f, vs_f, de_f, fd_f;
    logic [16:0] addr_f;
    logic [15:0] rdata_f;
    logic [3:0]  r_f, g_f, b_f;

    qvga_frame_reader dut_full (
        .pclk(pclk), .reset(rst_f), .oe(oe_f), .rAddr(addr_f), .rData(rdata_f),
        .h_sync(hs_f), .v_sync(vs_f), .de(de_f), .red(r_f), .green(g_f),
        .blue(b_f), .frame_done(fd_f)
    );

    // Synchronous-read memory; garbage is returned when no read is issued.
    always @(posedge pclk) begin
        rdata_s <= oe_s ? mem[addr_s] : 16'($urandom);
        rdata_f <= oe_f ? mem[addr_f] : 16'($urandom);
    end

    // Reference time base: edges since the last edge that sampled reset high.
    int ks = 0;
    int kf = 0;
    always @(posedge pclk) begin
        ks <= rst_s ? 0 : ks + 1;
        kf <= rst_f ? 0 : kf + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic logic [11:0] conv(input logic [15:0] m);
        int r5, g6, b5, sum;
        r5 = int'(m[15:11]);
        g6 = int'(m[10:5]);
        b5 = int'(m[4:0]);
`ifdef QVGA_READER_GRAY_EN
        sum = r5 * 77 * 8 + g6 * 150 * 4 + b5 * 29 * 8;
        sum = (sum >> 8) >> 4;
        return {4'(sum), 4'(sum), 4'(sum)};
`else
        return {4'(r5 >> 1), 4'(g6 >> 2), 4'(b5 >> 1)};
`endif
    endfunction

    // Expected behaviour from the raster rules, in terms of k.
    task automatic model(input int k, input logic rst,
                         input int ha, input int ht, input int hss, input int hse,
                         input int va, input int vt, input int vss, input int vse,
                         input int sw,
                         output logic e_oe, output logic [16:0] e_addr,
                         output logic e_hs, output logic e_vs, output logic e_de,
                         output logic [11:0] e_rgb, output logic e_fd);
        int h, v, c;
        h = k % ht;
        v = (k / ht) % vt;
        e_oe   = !rst && (h < ha) && (v < va);
        e_addr = e_oe ? 17'((v / 2) * sw + h / 2) : 17'd0;
        if (k < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 12'h000;
        end else begin
            c = k - 2;
            h = c % ht;
            v = (c / ht) % vt;
            e_hs  = !(h >= hss && h <= hse);
            e_vs  = !(v >= vss && v <= vse);
            e_de  = (h < ha) && (v < va);
            e_rgb = e_de ? conv(mem[(v / 2) * sw + h / 2]) : 12'h000;
        end
        e_fd = (k >= 1) && (((k - 1) % (ht * vt)) == (va - 1) * ht + ha - 1);
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model
    always @(negedge pclk) begin
        logic eo, ehs, evs, ede, efd;
        logic [16:0] ea;
        logic [11:0] ergb;
        if (checking) begin
            model(ks, rst_s, S_HA, S_HT, S_HSS, S_HSE, S_VA, S_VT, S_VSS, S_VSE, S_SW,
                  eo, ea, ehs, evs, ede, ergb, efd);
            check("s_oe", ks, 32'(oe_s), 32'(eo));
            check("s_addr", ks, 32'(addr_s), 32'(ea));
            check("s_hsync", ks, 32'(hs_s), 32'(ehs));
            check("s_vsync", ks, 32'(vs_s), 32'(evs));
            check("s_de", ks, 32'(de_s), 32'(ede));
            check("s_rgb", ks, 32'({r_s, g_s, b_s}), 32'(ergb));
            check("s_fdone", ks, 32'(fd_s), 32'(efd));
            model(kf, rst_f, F_HA, F_HT, F_HSS, F_HSE, F_VA, F_VT, F_VSS, F_VSE, F_SW,
                  eo, ea, ehs, evs, ede, ergb, efd);
            check("f_oe", kf, 32'(oe_f), 32'(eo));
            check("f_addr", kf, 32'(addr_f), 32'(ea));
            check("f_hsync", kf, 32'(hs_f), 32'(ehs));
            check("f_vsync", kf, 32'(vs_f), 32'(evs));
            check("f_de", kf, 32'(de_f), 32'(ede));
            check("f_rgb", kf, 32'({r_f, g_f, b_f}), 32'(ergb));
            check("f_fdone", kf, 32'(fd_f), 32'(efd));
        end
    end

    task automatic wait_ks(input int target);
        int n = 0;
        while (ks != target && n < 20000) begin
            @(negedge pclk);
            n++;
        end
        check("wait_ks", ks, 32'(ks), 32'(target));
    endtask

    task automatic wait_kf(input int target);
        int n = 0;
        while (kf != target && n < 20000) begin
            @(negedge pclk);
            n++;
        end
        check("wait_kf", kf, 32'(kf), 32'(target));
    endtask

`ifdef QVGA_READER_GRAY_EN
    localparam logic [11:0] MAGENTA_RGB = 12'h666;
`else
    localparam logic [11:0] MAGENTA_RGB = 12'hF0F;
`endif

    initial begin
        rst_s = 1'b1;
        rst_f = 1'b1;
        for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
        mem[641] = 16'hF81F;

        @(posedge pclk);
        checking = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_hsync", ks, 32'(hs_s), 32'h1);
        check("rst_vsync", ks, 32'(vs_s), 32'h1);
        check("rst_de", ks, 32'(de_s), 32'h0);
        check("rst_rgb", ks, 32'({r_s, g_s, b_s}), 32'h0);
        check("rst_oe", ks, 32'(oe_f), 32'h0);
        #1;
        rst_s = 1'b0;
        rst_f = 1'b0;
        @(negedge pclk);
        check("de_edge1", ks, 32'(de_s), 32'h0);
        @(negedge pclk);
        check("de_edge2", ks, 32'(de_s), 32'h1);

        fork
            begin : small_seq
                int fd_cnt, fd_first, hs_low, de_hi;
                // Reset while counters sit at h=30, v=10
                wait_ks(10 * S_HT + 30);
                #1 rst_s = 1'b1;
                @(negedge pclk);
                check("mid_rst_k", ks, 32'(ks), 32'h0);
                check("mid_rst_de", ks, 32'(de_s), 32'h0);
                check("mid_rst_rgb", ks, 32'({r_s, g_s, b_s}), 32'h0);
                check("mid_rst_fd", ks, 32'(fd_s), 32'h0);
                #1 rst_s = 1'b0;
                fd_cnt = 0; fd_first = -1; hs_low = 0; de_hi = 0;
                for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
                    @(negedge pclk);
                    if (fd_s) begin
                        fd_cnt++;
                        if (fd_first < 0) fd_first = ks;
                    end
                    if (ks >= 2 && ks < 2 + S_HT) begin
                        if (!hs_s) hs_low++;
                        if (de_s) de_hi++;
                    end
                    if (ks == 1489) check("s_last_addr", ks, 32'(addr_s), 32'd299);
                end
                check("fd_count", ks, 32'(fd_cnt), 32'd2);
                check("fd_first", ks, 32'(fd_first), 32'd1490);
                check("hs_low_line", ks, 32'(hs_low), 32'd4);
                check("de_hi_line", ks, 32'(de_hi), 32'd40);
                // Random reset pulses at random points of the raster
                for (int j = 0; j < 3; j++) begin
                    repeat ($urandom_range(0, 1800)) @(negedge pclk);
                    #1 rst_s = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge pclk);
                    #1 rst_s = 1'b0;
                end
                repeat (200) @(negedge pclk);
            end
            begin : full_seq
                wait_kf(640);
                check("f640_oe", kf, 32'(oe_f), 32'h0);
                check("f640_addr", kf, 32'(addr_f), 32'h0);
                wait_kf(5 * F_HT + 3);
                check("f_addr641", kf, 32'(addr_f), 32'd641);
                check("f_oe641", kf, 32'(oe_f), 32'h1);
                wait_kf(5 * F_HT + 2 + 2);
                check("f_px2_5", kf, 32'({r_f, g_f, b_f}), 32'(MAGENTA_RGB));
                wait_kf(5 * F_HT + 3 + 2);
                check("f_px3_5", kf, 32'({r_f, g_f, b_f}), 32'(MAGENTA_RGB));
            end
        join

        repeat (5) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
